// File: rtl/cdc_event_feeder.sv
// Source-domain feeder that queues event counts and meters them out as single-cycle pulses into a pulse CDC FIFO.
// Optional high-water-mark tracking is built only when CDC_EVENT_FEEDER_HWM_EN is defined.
module cdc_event_feeder #(
   parameter int CNT_WIDTH = 8,
   parameter int EVT_W     = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 evt_valid,
   input  logic [EVT_W-1:0]     evt_cnt,
   input  logic                 enable,
   input  logic                 flush,
   input  logic                 full,
   input  logic                 ovf_clr,
   output logic                 sigin,
   output logic [CNT_WIDTH-1:0] pending,
   output logic                 idle,
   output logic                 ovf_sticky,
   output logic [CNT_WIDTH-1:0] hwm
);

   localparam logic [CNT_WIDTH:0] MAX = {1'b0, {CNT_WIDTH{1'b1}}};

   logic                 r_sigin;
   logic [CNT_WIDTH-1:0] r_pending;
   logic                 r_ovf_sticky;

   logic                 w_issue;
   logic [CNT_WIDTH:0]   w_add;
   logic [CNT_WIDTH:0]   w_sum;
   logic                 w_sat;
   logic [CNT_WIDTH-1:0] w_next_pending;

   // Issue looks only at register values, so an event added this cycle cannot leave this cycle.
   assign w_issue = enable & ~full & (r_pending != '0) & ~flush;
   assign w_add   = evt_valid ? {{(CNT_WIDTH+1-EVT_W){1'b0}}, evt_cnt} : '0;
   // One extra bit holds pending+add; issue implies pending>0 so the subtraction never underflows.
   assign w_sum   = {1'b0, r_pending} + w_add - {{CNT_WIDTH{1'b0}}, w_issue};
   assign w_sat   = ~flush & (w_sum > MAX);

   always_comb begin
      w_next_pending = w_sum[CNT_WIDTH-1:0];
      if (flush)
         w_next_pending = '0;
      else if (w_sat)
         w_next_pending = MAX[CNT_WIDTH-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sigin      <= 1'b0;
         r_pending    <= '0;
         r_ovf_sticky <= 1'b0;
      end else begin
         r_sigin   <= w_issue;
         r_pending <= w_next_pending;
         if (w_sat)
            r_ovf_sticky <= 1'b1;
         else if (ovf_clr)
            r_ovf_sticky <= 1'b0;
      end
   end

`ifdef CDC_EVENT_FEEDER_HWM_EN
   logic [CNT_WIDTH-1:0] r_hwm;

   // ovf_clr restarts the watermark from the value pending is about to take.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_hwm <= '0;
      else if (ovf_clr)
         r_hwm <= w_next_pending;
      else if (w_next_pending > r_hwm)
         r_hwm <= w_next_pending;
   end

   assign hwm = r_hwm;
`else
   assign hwm = '0;
`endif

   assign sigin      = r_sigin;
   assign pending    = r_pending;
   assign ovf_sticky = r_ovf_sticky;
   assign idle       = (r_pending == '0) & ~r_sigin;

endmodule
